im_loader: RTL and testbench
============================

# im_loader

Program loader that writes the instruction memory from an external byte stream before the pipeline runs. It accepts bytes over a valid/ready handshake and packs four bytes into each 32-bit instruction word. It drives the instruction-memory write port (WE/ADDR/DATA) with sequential addresses from 0. It holds the CPU (PC, register bank, flags) in reset until a load completes without error.

## Interface
- ADDR_WIDTH, 8: instruction-memory word address width; depth = 2^ADDR_WIDTH words.
- CNT_WIDTH, 16: width of the requested word count.

- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- in_START  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- in_COUNT  in  CNT_WIDTH  number of words to load; sampled with in_START.
- in_VALID  in  1  byte-stream valid.
- in_BYTE  in  8  byte-stream data.
- out_READY  out  1  loader accepts a byte this cycle.
- out_im_WE  out  1  instruction-memory write enable.
- out_im_ADDR  out  ADDR_WIDTH  word address.
- out_im_DATA  out  32  word to write.
- out_CPU_HOLD  out  1  drive to pc/rb/tf reset; 1 = CPU held.
- out_BUSY  out  1  load in progress.
- out_DONE  out  1  one-cycle pulse at the end of a load.
- out_ERR  out  1  sticky error; cleared by the next accepted in_START.

## Operation
- Byte accept happens when in_VALID && out_READY.
- Packing is little-endian: the first byte goes to [7:0] and the fourth to [31:24].
- FSM states are IDLE, RECV, WRITE, CHECK (only with the macro), and FIN.
- IDLE:
  - On in_START, latch in_COUNT, clear out_ERR, set the address to 0 and the byte index to 0.
  - If COUNT == 0, go to FIN.
  - If COUNT > 2^ADDR_WIDTH, set out_ERR and go to FIN with no writes.
  - Otherwise go to RECV.
- RECV:
  - out_READY = 1.
  - The byte index counts 0..3.
  - The accept of byte 3 goes to WRITE.
- WRITE:
  - Lasts exactly one cycle, with out_READY = 0.
  - out_im_WE = 1 and out_im_DATA = the packed word.
  - The address increments after the write.
  - If the words written equal COUNT, go to CHECK (macro) or FIN; otherwise go to RECV.
- FIN:
  - out_DONE = 1 for one cycle, then go to IDLE.
  - out_CPU_HOLD drops when FIN is entered without error.
- out_CPU_HOLD is re-asserted on the next accepted in_START.
- out_BUSY = 1 in every state except IDLE.
- in_START outside IDLE is ignored.
- in_VALID outside RECV/CHECK is not accepted, and the byte stays with the source.

## Timing
- Reset values:
  - out_READY = 0, out_im_WE = 0, out_im_ADDR = 0, out_im_DATA = 0.
  - out_CPU_HOLD = 1, out_BUSY = 0, out_DONE = 0, out_ERR = 0.
  - State = IDLE.
- All outputs are registered.
- out_im_WE is asserted in the cycle after the 4th byte accept.
- Peak throughput is one word per 5 cycles.
- FIN follows the final WRITE (or CHECK) by 1 cycle.
- Reset mid-load:
  - Returns immediately to the reset values, with CPU held.
  - Words already written stay in instruction memory; a new in_START is required.
- A stalled stream (in_VALID = 0) holds the state and the byte index indefinitely.
- Address wrap cannot occur, because an oversize COUNT is rejected up front.

## Configuration
- IM_LOADER_CHECKSUM_EN:
  - When defined, one extra byte follows the last word, and the loader waits for it in CHECK with out_READY = 1.
  - That byte must equal the XOR of all data bytes.
  - On mismatch: out_ERR = 1, FIN pulses, out_CPU_HOLD stays 1.
  - When undefined: there is no CHECK state and no checksum byte, and out_ERR reports only an oversize COUNT.

## Structure
- Shared package `proc_pkg`:
  - FSM state encoding.
  - Constant IM_WORD_BYTES = 4.
  - Default widths.
- Sub-module `byte_packer`: byte index counter and 32-bit shift/assemble register, with clear and load-complete flag.
- The top holds the FSM, the address/word counters, and the checksum accumulator.

## Test plan
- Load of 2 words:
  - START with COUNT = 2, bytes 0x13,0x00,0x00,0x00,0x93,0x01,0x20,0x00 with continuous valid.
  - Expect WE at ADDR 0 with DATA 0x00000013, then at ADDR 1 with DATA 0x00200193.
  - Then a DONE pulse and CPU_HOLD falling.
- Backpressure/stall:
  - Drop in_VALID for 7 cycles after byte 2.
  - Expect no extra WE, the same word assembled, and no byte lost or duplicated.
- COUNT = 0:
  - Expect DONE 1 cycle after START, no WE, ERR = 0, CPU_HOLD = 0.
- COUNT = 257 with ADDR_WIDTH = 8:
  - Expect ERR = 1, DONE, no WE, CPU_HOLD = 1.
- Async reset mid-load:
  - Assert RESET_N low after byte 5 of a COUNT = 4 load.
  - Expect all outputs at reset values without waiting for a clock edge.
  - A subsequent START/COUNT = 1 load writes ADDR 0.
- With IM_LOADER_CHECKSUM_EN, COUNT = 1, bytes 0x01,0x02,0x04,0x08:
  - Checksum 0x0F: ERR = 0 and CPU released.
  - Checksum 0x0E: ERR = 1 and CPU_HOLD stays 1.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants and FSM encoding for the instruction-memory loader
// IM_LOADER_CHECKSUM_EN adds the CHECK state.
package proc_pkg;

  localparam int IM_WORD_BYTES  = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef IM_LOADER_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte stream, control and instruction-memory write port of the loader
interface im_loader_if
  import proc_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);

  logic                  in_START;
  logic [CNT_WIDTH-1:0]  in_COUNT;
  logic                  in_VALID;
  logic [7:0]            in_BYTE;
  logic                  out_READY;
  logic                  out_im_WE;
  logic [ADDR_WIDTH-1:0] out_im_ADDR;
  logic [31:0]           out_im_DATA;
  logic                  out_CPU_HOLD;
  logic                  out_BUSY;
  logic                  out_DONE;
  logic                  out_ERR;

  modport master (
    output in_START, in_COUNT, in_VALID, in_BYTE,
    input  out_READY, out_im_WE, out_im_ADDR, out_im_DATA,
    input  out_CPU_HOLD, out_BUSY, out_DONE, out_ERR
  );

  modport slave (
    input  in_START, in_COUNT, in_VALID, in_BYTE,
    output out_READY, out_im_WE, out_im_ADDR, out_im_DATA,
    output out_CPU_HOLD, out_BUSY, out_DONE, out_ERR
  );

endinterface

// File: rtl/im_loader_byte_packer.sv
// rtl/im_loader_byte_packer.sv - little-endian byte-to-word assembler with index counter
// The newest byte enters at [31:24]; after four shifts the first byte sits in [7:0].
module byte_packer
  import proc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word_next,
  output logic        last
);

  localparam int IW = $clog2(IM_WORD_BYTES);

  logic [IW-1:0] idx;
  logic [31:0]   word_q;

  assign word_next = {data, word_q[31:8]};
  assign last      = (idx == IW'(IM_WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx    <= '0;
      word_q <= '0;
    end else if (shift) begin
      idx    <= last ? '0 : idx + IW'(1);
      word_q <= word_next;
    end
  end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - loads instruction memory from a byte stream and holds the CPU until done
// IM_LOADER_CHECKSUM_EN: expect a trailing XOR checksum byte verified in CHECK.
module im_loader
  import proc_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
)(
  input  logic CLK,
  input  logic RESET_N,
  im_loader_if.slave bus
);

  localparam logic [CNT_WIDTH:0] DEPTH = (CNT_WIDTH + 1)'(1) << ADDR_WIDTH;

  state_t               state;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] wcnt;
  logic [CNT_WIDTH-1:0] wcnt_inc;
  logic                 ready_q, we_q, hold_q, busy_q, done_q, err_q;
  logic [31:0]          data_q;
  logic                 accept, pack_clear, pack_shift, pack_last;
  logic [31:0]          pack_word;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign accept     = bus.in_VALID && ready_q;
  assign pack_clear = (state == ST_IDLE) && bus.in_START;
  assign pack_shift = accept && (state == ST_RECV);
  assign wcnt_inc   = wcnt + CNT_WIDTH'(1);

  byte_packer u_packer (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .clear     (pack_clear),
    .shift     (pack_shift),
    .data      (bus.in_BYTE),
    .word_next (pack_word),
    .last      (pack_last)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      count_q <= '0;
      wcnt    <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_START) begin
            count_q <= bus.in_COUNT;
            wcnt    <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
            if (bus.in_COUNT == '0) begin
              state  <= ST_FIN;
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else if ({1'b0, bus.in_COUNT} > DEPTH) begin
              // Rejected up front so the word address can never wrap.
              state  <= ST_FIN;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state   <= ST_RECV;
              ready_q <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (accept) begin
`ifdef IM_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.in_BYTE;
`endif
            if (pack_last) begin
              state   <= ST_WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              data_q  <= pack_word;
            end
          end
        end
        ST_WRITE: begin
          wcnt <= wcnt_inc;
          if (wcnt_inc == count_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state   <= ST_CHECK;
            ready_q <= 1'b1;
`else
            state   <= ST_FIN;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
`endif
          end else begin
            state   <= ST_RECV;
            ready_q <= 1'b1;
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            state   <= ST_FIN;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
            if (bus.in_BYTE == csum) hold_q <= 1'b0;
            else                     err_q  <= 1'b1;
          end
        end
`endif
        ST_FIN: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_READY    = ready_q;
  assign bus.out_im_WE    = we_q;
  assign bus.out_im_ADDR  = wcnt[ADDR_WIDTH-1:0];
  assign bus.out_im_DATA  = data_q;
  assign bus.out_CPU_HOLD = hold_q;
  assign bus.out_BUSY     = busy_q;
  assign bus.out_DONE     = done_q;
  assign bus.out_ERR      = err_q;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - self-checking bench for im_loader against a word-list reference model
// IM_LOADER_CHECKSUM_EN: appends the XOR checksum byte and runs the checksum cases.
module tb_im_loader;
  import proc_pkg::*;

  localparam int AW   = 8;
  localparam int CW   = 16;
  localparam int FULL = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  im_loader_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus();

  im_loader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_im_WE) begin
      got_addr.push_back(bus.out_im_ADDR);
      got_data.push_back(bus.out_im_DATA);
      chk("ready_during_we", bus.out_READY, 0);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.out_READY, 0);
    chk({tag, "_we"},    bus.out_im_WE, 0);
    chk({tag, "_addr"},  bus.out_im_ADDR, 0);
    chk({tag, "_data"},  bus.out_im_DATA, 0);
    chk({tag, "_hold"},  bus.out_CPU_HOLD, 1);
    chk({tag, "_busy"},  bus.out_BUSY, 0);
    chk({tag, "_done"},  bus.out_DONE, 0);
    chk({tag, "_err"},   bus.out_ERR, 0);
  endtask

  task automatic compare_writes();
    chk("n_writes", got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      chk("wr_addr", got_addr[i], exp_addr[i]);
      chk("wr_data", got_data[i], exp_data[i]);
    end
    got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] d[$]);
    d.delete();
    for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
  endtask

  // Model: word i = bytes 4i..4i+3 little-endian at address i; WE follows every 4th data byte.
  task automatic run_load(input int cnt, input logic [7:0] d[$], input bit cont,
                          input int stall_at, input int stall_len, input int stop_at,
                          input bit bad_cs);
    logic [7:0] s[$];
    logic [7:0] x;
    int n, cyc, stalled, nbytes;
    bit acc, exp_we, v;
    s = d;
    x = 8'h00;
    foreach (d[i]) x = x ^ d[i];
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back(AW'(i));
      exp_data.push_back({d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
    end
`ifdef IM_LOADER_CHECKSUM_EN
    s.push_back(bad_cs ? (x ^ 8'h01) : x);
`endif
    nbytes = s.size();
    if (stop_at > nbytes) stop_at = nbytes;
    @(negedge clk);
    bus.in_START = 1'b1;
    bus.in_COUNT = CW'(cnt);
    @(negedge clk);
    bus.in_START = 1'b0;
    chk("start_busy", bus.out_BUSY, 1);
    chk("start_hold", bus.out_CPU_HOLD, 1);
    chk("start_err", bus.out_ERR, 0);
    n = 0; cyc = 0; stalled = 0; exp_we = 0;
    while (n < stop_at && cyc < 20 * nbytes + 100) begin
      chk("we_timing", bus.out_im_WE, exp_we);
      if (n == stall_at && stalled < stall_len) begin
        v = 1'b0;
        stalled++;
      end else begin
        v = cont || ($urandom_range(0, 3) != 0);
      end
      bus.in_VALID = v;
      bus.in_BYTE  = v ? s[n] : 8'($urandom);
      bus.in_START = ($urandom_range(0, 15) == 0);
      acc = v && bus.out_READY;
      if (acc) n++;
      exp_we = acc && (n <= 4 * cnt) && (n % 4 == 0);
      @(negedge clk);
      cyc++;
    end
    bus.in_VALID = 1'b0;
    bus.in_START = 1'b0;
    chk("we_timing", bus.out_im_WE, exp_we);
    chk("bytes_accepted", n, stop_at);
    if (stop_at == nbytes) begin
`ifndef IM_LOADER_CHECKSUM_EN
      @(negedge clk);
`endif
      chk("done_pulse", bus.out_DONE, 1);
      chk("end_err", bus.out_ERR, bad_cs);
      chk("end_hold", bus.out_CPU_HOLD, bad_cs);
      @(negedge clk);
      chk("done_clear", bus.out_DONE, 0);
      chk("idle_busy", bus.out_BUSY, 0);
      compare_writes();
    end
  endtask

  task automatic run_short(input int cnt, input bit exp_err);
    @(negedge clk);
    bus.in_START = 1'b1;
    bus.in_COUNT = CW'(cnt);
    @(negedge clk);
    bus.in_START = 1'b0;
    chk("short_done", bus.out_DONE, 1);
    chk("short_err", bus.out_ERR, exp_err);
    chk("short_hold", bus.out_CPU_HOLD, exp_err);
    chk("short_busy", bus.out_BUSY, 1);
    @(negedge clk);
    chk("short_done_clear", bus.out_DONE, 0);
    chk("short_idle", bus.out_BUSY, 0);
    chk("short_no_we", got_data.size(), 0);
  endtask

  initial begin
    logic [7:0] d[$];
    int c;
    bus.in_START = 1'b0;
    bus.in_COUNT = '0;
    bus.in_VALID = 1'b0;
    bus.in_BYTE  = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    d = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h20, 8'h00};
    run_load(2, d, 1'b1, -1, 0, FULL, 1'b0);

    rand_bytes(12, d);
    run_load(3, d, 1'b1, 2, 7, FULL, 1'b0);

    for (int k = 0; k < 4; k++) begin
      c = $urandom_range(1, 6);
      rand_bytes(4 * c, d);
      run_load(c, d, 1'b0, $urandom_range(0, 4 * c - 1), $urandom_range(0, 5), FULL, 1'b0);
    end

    run_short(0, 1'b0);
    run_short(257, 1'b1);

    rand_bytes(4 * 256, d);
    run_load(256, d, 1'b1, -1, 0, FULL, 1'b0);

    rand_bytes(16, d);
    run_load(4, d, 1'b1, -1, 0, 5, 1'b0);
    got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    rand_bytes(4, d);
    run_load(1, d, 1'b0, -1, 0, FULL, 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
    d = {8'h01, 8'h02, 8'h04, 8'h08};
    run_load(1, d, 1'b1, -1, 0, FULL, 1'b1);
    run_load(1, d, 1'b1, -1, 0, FULL, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
